// File: rtl/zxw_dm_arbiter_v_if.sv
// Request/acknowledge port between one requester and the data-memory arbiter.
// The requester holds req/we/addr/wdata stable until it sees ack.
// The arbiter returns a one-cycle ack, and rdata is held after the ack.
interface zxw_dm_arbiter_v_if #(
   parameter int AW = 8,
   parameter int DW = 4
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/zxw_dm_arbiter_v.sv
// zxw_dm_arbiter_v: shares the single-port data RAM and the MMIO registers
// between M0 (CPU data port) and M1 (host/loader port).
// Only one transaction is in flight at a time, and each one takes 3 cycles
// (IDLE -> ACC -> DONE).
// The MMIO window at PB_ADDR..DHR_ADDR (0xFC-0xFF) is decoded here, so the
// RAM never sees a write strobe for those addresses.
// Build option ZXW_ARB_FIXED_PRIO_EN: when it is defined, M0 always wins a tie.
// When it is undefined, ties are resolved round-robin using last_gnt.
//
// state | meaning
// IDLE  | wait for a request; latch the granted master's we/addr/wdata
// ACC   | RAM access (the RAM clocks on the falling edge); MMIO update on exit
// DONE  | one-cycle ack to the granted master
module zxw_dm_arbiter_v #(
   parameter int            AW       = 8,
   parameter int            DW       = 4,
   parameter logic [AW-1:0] DHR_ADDR = AW'(8'hFF),
   parameter logic [AW-1:0] DLR_ADDR = AW'(8'hFE),
   parameter logic [AW-1:0] SW_ADDR  = AW'(8'hFD),
   parameter logic [AW-1:0] PB_ADDR  = AW'(8'hFC)
) (
   input  logic                 Clock_pin,
   input  logic                 Resetn_pin,
   zxw_dm_arbiter_v_if.slave    m0,
   zxw_dm_arbiter_v_if.slave    m1,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   output logic                 ram_we,
   input  logic [DW-1:0]        ram_rdata,
   input  logic [DW-1:0]        SW_pin,
   input  logic [DW-1:0]        PB_pin,
   output logic [DW-1:0]        DHR_pin,
   output logic [DW-1:0]        DLR_pin
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;          // 0 = M0, 1 = M1
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;
   logic [DW-1:0] dhr_q, dhr_d;
   logic [DW-1:0] dlr_q, dlr_d;
   logic [DW-1:0] rd_mux;
   logic          is_mmio;
`ifndef ZXW_ARB_FIXED_PRIO_EN
   logic          last_gnt_q, last_gnt_d;
`endif

   assign is_mmio = (addr_q >= PB_ADDR);

   // Read-data source for the latched address; SW/PB are sampled live at the end of ACC.
   always_comb begin
      rd_mux = ram_rdata;
      if (addr_q == DHR_ADDR)      rd_mux = dhr_q;
      else if (addr_q == DLR_ADDR) rd_mux = dlr_q;
      else if (addr_q == SW_ADDR)  rd_mux = SW_pin;
      else if (addr_q == PB_ADDR)  rd_mux = PB_pin;
   end

   // Next-state, grant selection, read latching and MMIO register writes.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      dhr_d      = dhr_q;
      dlr_d      = dlr_q;
`ifndef ZXW_ARB_FIXED_PRIO_EN
      last_gnt_d = last_gnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m0.req || m1.req) begin
`ifdef ZXW_ARB_FIXED_PRIO_EN
               gnt_d = !m0.req;
`else
               gnt_d = (m0.req && m1.req) ? !last_gnt_q : m1.req;
`endif
               we_d    = gnt_d ? m1.we    : m0.we;
               addr_d  = gnt_d ? m1.addr  : m0.addr;
               wdata_d = gnt_d ? m1.wdata : m0.wdata;
               state_d = ACC;
            end
         end
         ACC: begin
            if (!we_q) begin
               if (gnt_q) m1_rdata_d = rd_mux;
               else       m0_rdata_d = rd_mux;
            end else begin
               if (addr_q == DHR_ADDR) dhr_d = wdata_q;
               if (addr_q == DLR_ADDR) dlr_d = wdata_q;
            end
`ifndef ZXW_ARB_FIXED_PRIO_EN
            last_gnt_d = gnt_q;
`endif
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset leaves last_gnt = M1 so that M0 wins the first tie.
   always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
      if (!Resetn_pin) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         dhr_q      <= '0;
         dlr_q      <= '0;
`ifndef ZXW_ARB_FIXED_PRIO_EN
         last_gnt_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         dhr_q      <= dhr_d;
         dlr_q      <= dlr_d;
`ifndef ZXW_ARB_FIXED_PRIO_EN
         last_gnt_q <= last_gnt_d;
`endif
      end
   end

   // Outputs are decoded from registers only, so reset clears them immediately.
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = (state_q == ACC) && we_q && !is_mmio;
      m0.ack    = (state_q == DONE) && !gnt_q;
      m1.ack    = (state_q == DONE) &&  gnt_q;
      m0.rdata  = m0_rdata_q;
      m1.rdata  = m1_rdata_q;
      DHR_pin   = dhr_q;
      DLR_pin   = dlr_q;
   end

endmodule

// File: tb/tb_zxw_dm_arbiter_v.sv
// Directed bench for zxw_dm_arbiter_v.
// A table of single transactions is applied first.
// It is followed by hand-written sequences for ties, reset in ACC, and req dropped during ACC.
module tb_zxw_dm_arbiter_v;
   logic       clk;
   logic       rst_n;
   logic [7:0] ram_addr;
   logic [3:0] ram_wdata;
   logic       ram_we;
   logic [3:0] ram_rdata;
   logic [3:0] sw, pb, dhr, dlr;
   logic [3:0] mem [256];

   int n_vec = 0;
   int n_err = 0;

   zxw_dm_arbiter_v_if #(.AW(8), .DW(4)) m0_if ();
   zxw_dm_arbiter_v_if #(.AW(8), .DW(4)) m1_if ();

   zxw_dm_arbiter_v dut (
      .Clock_pin (clk),
      .Resetn_pin(rst_n),
      .m0        (m0_if),
      .m1        (m1_if),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .SW_pin    (sw),
      .PB_pin    (pb),
      .DHR_pin   (dhr),
      .DLR_pin   (dlr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM behaves like zxw_ram_v: it is clocked on the falling edge, and the read is registered.
   always @(negedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      bit         m;
      bit         we;
      logic [7:0] addr;
      logic [3:0] wdata;
      logic [3:0] exp_rd;
      bit         exp_we;
      logic [3:0] exp_dhr;
      logic [3:0] exp_dlr;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit m, input bit req, input bit we, input logic [7:0] a, input logic [3:0] d);
      if (!m) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
      end
   endtask

   // Runs one transaction from IDLE and returns in the next IDLE cycle.
   task automatic txn(input bit m, input bit we, input logic [7:0] a, input logic [3:0] d,
                      output logic [3:0] rd, output bit saw_we, output int lat);
      bit got;
      got = 0; saw_we = 0; lat = 0; rd = '0;
      @(negedge clk);
      drive(m, 1'b1, we, a, d);
      while (!got && lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (ram_we) saw_we = 1;
         if ((m ? m1_if.ack : m0_if.ack) === 1'b1) got = 1;
      end
      drive(m, 1'b0, we, a, d);
      rd = m ? m1_if.rdata : m0_if.rdata;
      @(posedge clk);
   endtask

   // Ties: both masters request together, each drops req on its own ack.
   task automatic tie(input logic [7:0] a0, input logic [7:0] a1, output int t0, output int t1);
      t0 = 0; t1 = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, a0, 4'h0);
      drive(1, 1'b1, 1'b0, a1, 4'h0);
      for (int c = 1; c <= 12 && (t0 == 0 || t1 == 0); c++) begin
         @(posedge clk); #1;
         if (m0_if.ack === 1'b1) begin t0 = c; m0_if.req = 1'b0; end
         if (m1_if.ack === 1'b1) begin t1 = c; m1_if.req = 1'b0; end
      end
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      logic [3:0] rd;
      bit         sw_e;
      int         lat, t0, t1, nack, first;

      for (int i = 0; i < 256; i++) mem[i] = 4'h0;
      sw = 4'h9; pb = 4'h6;
      drive(0, 1'b0, 1'b0, 8'h00, 4'h0);
      drive(1, 1'b0, 1'b0, 8'h00, 4'h0);
      rst_n = 1'b0;

      //            m  we addr   wd    rd    ram_we dhr   dlr
      vt[0]  = '{0, 1, 8'h10, 4'hA, 4'h0, 1, 4'h0, 4'h0};
      vt[1]  = '{0, 0, 8'h10, 4'h0, 4'hA, 0, 4'h0, 4'h0};
      vt[2]  = '{1, 1, 8'hFF, 4'h5, 4'h0, 0, 4'h5, 4'h0};
      vt[3]  = '{1, 1, 8'hFE, 4'h3, 4'h0, 0, 4'h5, 4'h3};
      vt[4]  = '{1, 0, 8'hFF, 4'h0, 4'h5, 0, 4'h5, 4'h3};
      vt[5]  = '{0, 0, 8'hFE, 4'h0, 4'h3, 0, 4'h5, 4'h3};
      vt[6]  = '{0, 0, 8'hFD, 4'h0, 4'h9, 0, 4'h5, 4'h3};
      vt[7]  = '{0, 0, 8'hFC, 4'h0, 4'h6, 0, 4'h5, 4'h3};
      vt[8]  = '{0, 1, 8'hFD, 4'hF, 4'h0, 0, 4'h5, 4'h3};
      vt[9]  = '{1, 1, 8'hFB, 4'h7, 4'h0, 1, 4'h5, 4'h3};
      vt[10] = '{0, 0, 8'hFB, 4'h0, 4'h7, 0, 4'h5, 4'h3};
      vt[11] = '{1, 0, 8'h10, 4'h0, 4'hA, 0, 4'h5, 4'h3};
      vt[12] = '{0, 1, 8'h20, 4'hC, 4'h0, 1, 4'h5, 4'h3};
      vt[13] = '{1, 1, 8'h21, 4'hD, 4'h0, 1, 4'h5, 4'h3};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m0_ack", {7'd0, m0_if.ack}, 8'h00);
      chk("rst_m1_ack", {7'd0, m1_if.ack}, 8'h00);
      chk("rst_ram_we", {7'd0, ram_we}, 8'h00);
      chk("rst_ram_addr", ram_addr, 8'h00);
      chk("rst_dhr", {4'd0, dhr}, 8'h00);
      chk("rst_dlr", {4'd0, dlr}, 8'h00);
      chk("rst_m0_rdata", {4'd0, m0_if.rdata}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      for (int i = 0; i < 14; i++) begin
         txn(vt[i].m, vt[i].we, vt[i].addr, vt[i].wdata, rd, sw_e, lat);
         chk($sformatf("v%0d_latency", i), 8'(lat), 8'd2);
         chk($sformatf("v%0d_ram_we", i), {7'd0, sw_e}, {7'd0, vt[i].exp_we});
         chk($sformatf("v%0d_dhr", i), {4'd0, dhr}, {4'd0, vt[i].exp_dhr});
         chk($sformatf("v%0d_dlr", i), {4'd0, dlr}, {4'd0, vt[i].exp_dlr});
         if (!vt[i].we) chk($sformatf("v%0d_rdata", i), {4'd0, rd}, {4'd0, vt[i].exp_rd});
      end

      // The last grant went to M1, so M0 wins this tie under both policies.
      tie(8'h20, 8'h21, t0, t1);
      chk("tie1_m0_cycle", 8'(t0), 8'd2);
      chk("tie1_m1_cycle", 8'(t1), 8'd5);
      chk("tie1_m0_rdata", {4'd0, m0_if.rdata}, 8'h0C);
      chk("tie1_m1_rdata", {4'd0, m1_if.rdata}, 8'h0D);

      // After M0 is served alone, round-robin must favour M1 on the next tie.
      txn(0, 0, 8'h20, 4'h0, rd, sw_e, lat);
      tie(8'h10, 8'h21, t0, t1);
`ifdef ZXW_ARB_FIXED_PRIO_EN
      chk("tie2_m0_cycle", 8'(t0), 8'd2);
      chk("tie2_m1_cycle", 8'(t1), 8'd5);
`else
      chk("tie2_m1_cycle", 8'(t1), 8'd2);
      chk("tie2_m0_cycle", 8'(t0), 8'd5);
`endif
      chk("tie2_m0_rdata", {4'd0, m0_if.rdata}, 8'h0A);

      // Reset asserted during ACC of an M0 read.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 8'h21, 4'h0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_m0_ack", {7'd0, m0_if.ack}, 8'h00);
      chk("mid_rst_ram_we", {7'd0, ram_we}, 8'h00);
      chk("mid_rst_ram_addr", ram_addr, 8'h00);
      chk("mid_rst_m0_rdata", {4'd0, m0_if.rdata}, 8'h00);
      chk("mid_rst_dhr", {4'd0, dhr}, 8'h00);
      chk("mid_rst_dlr", {4'd0, dlr}, 8'h00);
      m0_if.req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nack = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (m0_if.ack === 1'b1 || m1_if.ack === 1'b1) nack++;
      end
      chk("post_rst_no_ack", 8'(nack), 8'd0);
      txn(1, 0, 8'h10, 4'h0, rd, sw_e, lat);
      chk("post_rst_m1_latency", 8'(lat), 8'd2);
      chk("post_rst_m1_rdata", {4'd0, rd}, 8'h0A);
      txn(1, 0, 8'hFF, 4'h0, rd, sw_e, lat);
      chk("post_rst_dhr_read", {4'd0, rd}, 8'h00);

      // M0 drops req during ACC: the access still completes with exactly one ack.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 8'hFB, 4'h0);
      @(posedge clk); #1;
      m0_if.req = 1'b0;
      nack = 0; first = 0;
      for (int c = 2; c <= 7; c++) begin
         @(posedge clk); #1;
         if (m0_if.ack === 1'b1) begin
            nack++;
            if (first == 0) first = c;
         end
      end
      chk("drop_ack_count", 8'(nack), 8'd1);
      chk("drop_ack_cycle", 8'(first), 8'd2);
      chk("drop_rdata", {4'd0, m0_if.rdata}, 8'h07);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
